lbm_step_sequencer: RTL and testbench
=====================================

Name: lbm_step_sequencer

Overview:
- Top-level scheduler for the D2Q9 lattice-Boltzmann datapath.
- Runs MAX_TIME time steps. Each step sweeps the grid through four phases in order: MACRO (rho/ux/uy), COLLIDE, STREAM, BOUNDARY.
- Issues one cell address at a time over a valid/ready handshake and tracks outstanding cells.
- Toggles the f-buffer ping-pong select at the end of every step.

Parameters:
- GRID_W, 16: lattice edge length; grid is square, GRID_DIM = GRID_W*GRID_W.
- GRID_DIM, 256: total cells.
- ADDRESS_WIDTH, $clog2(GRID_DIM): cell address width.
- MAX_TIME, 8: number of time steps per run.
- TIME_COUNT_WIDTH, $clog2(MAX_TIME): time-step counter width.
- MAX_OUTSTANDING, 4: maximum number of accepted-but-not-retired cells.

Ports:
- CLOCK_50, in, 1: sole clock.
- RESET, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a run; sampled only in IDLE.
- busy, out, 1: high from MACRO through BOUNDARY of the last step.
- done, out, 1: high while in DONE.
- err, out, 1: sticky; set on cmpl while outstanding==0.
- phase, out, 3: 0 IDLE, 1 MACRO, 2 COLLIDE, 3 STREAM, 4 BOUNDARY, 5 DONE.
- cell_addr, out, ADDRESS_WIDTH: row-major address, row*GRID_W+col.
- cell_valid, out, 1: cell_addr is valid.
- cell_ready, in, 1: datapath accepts the cell.
- cell_last, out, 1: current address is the final one of the phase.
- cmpl, in, 1: pulse; datapath retired one cell.
- time_step, out, TIME_COUNT_WIDTH: current step, 0..MAX_TIME-1.
- buf_sel, out, 1: f-buffer read bank; write bank is ~buf_sel.

Behaviour:
- Reset values (async on RESET low): phase=IDLE, all outputs 0, counters 0.
- Accept: cell_valid && cell_ready. On accept, advance the address and increment outstanding.
- cmpl decrements outstanding. Accept and cmpl in the same cycle leave outstanding unchanged.
- cell_valid is low when outstanding==MAX_OUTSTANDING, or when the phase's address sweep is exhausted. It never drops while waiting on cell_ready unless the sweep is exhausted.
- cell_addr is held stable while cell_valid && !cell_ready.
- MACRO, COLLIDE, STREAM sweep addresses 0..GRID_DIM-1, so cell_last=1 at GRID_DIM-1.
- BOUNDARY sweeps perimeter cells only, 4*GRID_W-4 of them, in this order:
  - row 0, col 0..W-1;
  - rows 1..W-2, col 0 then col W-1;
  - row W-1, col 0..W-1.
  - cell_last is set at address GRID_DIM-1.
- Phase exit: sweep exhausted AND outstanding==0 AND no cmpl in that cycle. The next phase starts the following cycle with cell_valid=1 at its first address. This gives exactly one dead cycle between phases.
- BOUNDARY exit:
  - time_step<MAX_TIME-1: toggle buf_sel, increment time_step, go to MACRO.
  - otherwise: go to DONE. time_step holds MAX_TIME-1; buf_sel toggles.
- Start latency: start=1 in IDLE at cycle n gives phase=MACRO, busy=1, cell_valid=1, cell_addr=0 at cycle n+1.
- DONE holds until start=1. start then clears done, time_step, buf_sel and err (same latency as from IDLE).
- start while busy is ignored.
- cmpl with outstanding==0: sets err; outstanding stays 0 (no underflow).
- RESET low mid-run aborts immediately to reset values; in-flight cmpl pulses after reset release set err.

Optional Feature:
- Macro: LBM_SEQ_SINGLE_STEP_EN.
- Defined:
  - adds input step (1 bit) and state HOLD (phase code 6);
  - after each non-final BOUNDARY exit, buf_sel and time_step update, then the FSM waits in HOLD (busy=1, cell_valid=0);
  - a step pulse moves HOLD to MACRO on the next cycle.
- Undefined: no step port, no HOLD; steps run back-to-back.

Decomposition:
- Package lbm_pkg holds:
  - phase_t enum (codes above);
  - DATA_WIDTH=32 and FRACTIONAL_BITS=24 constants;
  - Q-format helpers.
- Sub-module lbm_perim_addr_gen: perimeter address generator with load, advance, addr and last. Instantiated once for the BOUNDARY sweep.
- The full-grid sweep is a plain counter inside the sequencer.

Test Plan:
- Reset low mid-STREAM at cell 37 -> next cycle phase=0, cell_valid=0, busy=0, time_step=0, outstanding=0.
- GRID_W=4, MAX_TIME=2, cell_ready=1, cmpl one cycle after each accept -> 16+16+16+12=60 accepts per step, 120 total.
  - BOUNDARY order: 0,1,2,3,4,7,8,11,12,13,14,15.
  - buf_sel sequence 0→1→0; done=1 after the last retire; err=0.
- cmpl withheld -> exactly MAX_OUTSTANDING=4 accepts (addrs 0..3), then cell_valid=0. One cmpl -> addr 4 issued the next cycle.
- cell_ready low 5 cycles at addr 9 -> cell_addr=9 and cell_valid=1 held stable; accept on the 6th cycle.
- cmpl in IDLE -> err=1. start -> err=0, phase=1 next cycle. start pulsed during COLLIDE -> no effect.
- LBM_SEQ_SINGLE_STEP_EN defined -> after step 0 BOUNDARY: phase=6, time_step=1, buf_sel=1. No accepts for 20 cycles. step pulse -> phase=1, cell_addr=0 next cycle.

Source files
------------

// File: rtl/lbm_pkg.sv
// Shared types and fixed-point helpers for the D2Q9 lattice-Boltzmann datapath.
// Phase codes are visible on the sequencer's phase output.
package lbm_pkg;

  typedef enum logic [2:0] {
    PhIdle     = 3'd0,
    PhMacro    = 3'd1,
    PhCollide  = 3'd2,
    PhStream   = 3'd3,
    PhBoundary = 3'd4,
    PhDone     = 3'd5,
    PhHold     = 3'd6
  } phase_t;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned FRACTIONAL_BITS = 24;

  typedef logic signed [DATA_WIDTH-1:0] q_t;

  function automatic q_t q_from_int(input int value);
    q_t r;
    r = q_t'(value);
    return r <<< FRACTIONAL_BITS;
  endfunction

  function automatic int q_to_int(input q_t value);
    return int'(value >>> FRACTIONAL_BITS);
  endfunction

  // Full-width product, then drop the extra fraction bits.
  function automatic q_t q_mul(input q_t a, input q_t b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return p[FRACTIONAL_BITS +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/lbm_perim_addr_gen.sv
// Perimeter address walker for the BOUNDARY sweep: row 0 left to right, then
// col 0 and col W-1 of each middle row, then the last row left to right.
module lbm_perim_addr_gen #(
  parameter int unsigned GridW     = 16,
  parameter int unsigned AddrWidth = $clog2(GridW * GridW)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 advance_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 last_o
);

  localparam int unsigned IdxWidth = (GridW > 1) ? $clog2(GridW) : 1;
  localparam logic [IdxWidth-1:0] IdxMax = IdxWidth'(GridW - 1);

  logic [IdxWidth-1:0] row_q, row_d;
  logic [IdxWidth-1:0] col_q, col_d;
  logic                edge_row;

  assign edge_row = (row_q == '0) || (row_q == IdxMax);
  assign last_o   = (row_q == IdxMax) && (col_q == IdxMax);
  assign addr_o   = AddrWidth'(row_q) * AddrWidth'(GridW) + AddrWidth'(col_q);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (load_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i && !last_o) begin
      if (edge_row) begin
        if (col_q == IdxMax) begin
          row_d = row_q + IdxWidth'(1);
          col_d = '0;
        end else begin
          col_d = col_q + IdxWidth'(1);
        end
      end else if (col_q == '0) begin
        // Middle rows only visit the two side columns.
        col_d = IdxMax;
      end else begin
        row_d = row_q + IdxWidth'(1);
        col_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/lbm_step_sequencer.sv
// Time-step scheduler for the D2Q9 datapath: MACRO, COLLIDE, STREAM, BOUNDARY per step.
// Optional LBM_SEQ_SINGLE_STEP_EN adds a step input and a HOLD state between steps.
module lbm_step_sequencer
  import lbm_pkg::*;
#(
  parameter int unsigned GRID_W           = 16,
  parameter int unsigned GRID_DIM         = GRID_W * GRID_W,
  parameter int unsigned ADDRESS_WIDTH    = $clog2(GRID_DIM),
  parameter int unsigned MAX_TIME         = 8,
  parameter int unsigned TIME_COUNT_WIDTH = $clog2(MAX_TIME),
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        start,
`ifdef LBM_SEQ_SINGLE_STEP_EN
  input  logic                        step,
`endif
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [2:0]                  phase,
  output logic [ADDRESS_WIDTH-1:0]    cell_addr,
  output logic                        cell_valid,
  input  logic                        cell_ready,
  output logic                        cell_last,
  input  logic                        cmpl,
  output logic [TIME_COUNT_WIDTH-1:0] time_step,
  output logic                        buf_sel
);

  localparam int unsigned OutWidth = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDRESS_WIDTH-1:0]    LastAddr = ADDRESS_WIDTH'(GRID_DIM - 1);
  localparam logic [TIME_COUNT_WIDTH-1:0] LastStep = TIME_COUNT_WIDTH'(MAX_TIME - 1);
  localparam logic [OutWidth-1:0]         OutMax   = OutWidth'(MAX_OUTSTANDING);

  phase_t                        phase_q, phase_d;
  logic [ADDRESS_WIDTH-1:0]      addr_q, addr_d;
  logic                          exhausted_q, exhausted_d;
  logic [OutWidth-1:0]           out_q, out_d;
  logic [TIME_COUNT_WIDTH-1:0]   ts_q, ts_d;
  logic                          buf_sel_q, buf_sel_d;
  logic                          err_q, err_d;

  logic                          sweep_phase;
  logic                          accept;
  logic                          retire;
  logic                          exit_ok;
  logic                          perim_load;
  logic                          perim_adv;
  logic [ADDRESS_WIDTH-1:0]      perim_addr;
  logic                          perim_last;

  lbm_perim_addr_gen #(
    .GridW     (GRID_W),
    .AddrWidth (ADDRESS_WIDTH)
  ) u_perim (
    .clk_i     (CLOCK_50),
    .rst_ni    (RESET),
    .load_i    (perim_load),
    .advance_i (perim_adv),
    .addr_o    (perim_addr),
    .last_o    (perim_last)
  );

  assign sweep_phase = phase_q inside {PhMacro, PhCollide, PhStream, PhBoundary};
  assign cell_valid  = sweep_phase && !exhausted_q && (out_q < OutMax);
  assign cell_addr   = (phase_q == PhBoundary) ? perim_addr : addr_q;
  assign cell_last   = cell_valid && ((phase_q == PhBoundary) ? perim_last : (addr_q == LastAddr));
  assign accept      = cell_valid && cell_ready;
  // A completion with nothing outstanding is an error, never a decrement.
  assign retire      = cmpl && (out_q != '0);
  assign exit_ok     = exhausted_q && (out_q == '0) && !cmpl;

  assign busy      = sweep_phase || (phase_q == PhHold);
  assign done      = (phase_q == PhDone);
  assign err       = err_q;
  assign phase     = phase_q;
  assign time_step = ts_q;
  assign buf_sel   = buf_sel_q;

  always_comb begin
    phase_d     = phase_q;
    addr_d      = addr_q;
    exhausted_d = exhausted_q;
    out_d       = out_q;
    ts_d        = ts_q;
    buf_sel_d   = buf_sel_q;
    err_d       = err_q;
    perim_load  = 1'b0;
    perim_adv   = 1'b0;

    unique case ({accept, retire})
      2'b10:   out_d = out_q + OutWidth'(1);
      2'b01:   out_d = out_q - OutWidth'(1);
      default: out_d = out_q;
    endcase

    if (accept) begin
      if (cell_last) begin
        exhausted_d = 1'b1;
      end else if (phase_q == PhBoundary) begin
        perim_adv = 1'b1;
      end else begin
        addr_d = addr_q + ADDRESS_WIDTH'(1);
      end
    end

    if (sweep_phase && exit_ok) begin
      exhausted_d = 1'b0;
      addr_d      = '0;
    end

    unique case (phase_q)
      PhIdle, PhDone: begin
        if (start) begin
          phase_d   = PhMacro;
          ts_d      = '0;
          buf_sel_d = 1'b0;
          err_d     = 1'b0;
          addr_d    = '0;
        end
      end
      PhMacro: begin
        if (exit_ok) phase_d = PhCollide;
      end
      PhCollide: begin
        if (exit_ok) phase_d = PhStream;
      end
      PhStream: begin
        if (exit_ok) begin
          phase_d    = PhBoundary;
          perim_load = 1'b1;
        end
      end
      PhBoundary: begin
        if (exit_ok) begin
          buf_sel_d = ~buf_sel_q;
          if (ts_q != LastStep) begin
            ts_d = ts_q + TIME_COUNT_WIDTH'(1);
`ifdef LBM_SEQ_SINGLE_STEP_EN
            phase_d = PhHold;
`else
            phase_d = PhMacro;
`endif
          end else begin
            phase_d = PhDone;
          end
        end
      end
`ifdef LBM_SEQ_SINGLE_STEP_EN
      PhHold: begin
        if (step) phase_d = PhMacro;
      end
`endif
      default: phase_d = PhIdle;
    endcase

    if (cmpl && (out_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      phase_q     <= PhIdle;
      addr_q      <= '0;
      exhausted_q <= 1'b0;
      out_q       <= '0;
      ts_q        <= '0;
      buf_sel_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      exhausted_q <= exhausted_d;
      out_q       <= out_d;
      ts_q        <= ts_d;
      buf_sel_q   <= buf_sel_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Self-checking bench for lbm_step_sequencer on a 4x4 grid, two time steps.
// Build with LBM_SEQ_SINGLE_STEP_EN defined to also exercise the HOLD state.
module tb_lbm_step_sequencer;

  localparam int unsigned GRID_W   = 4;
  localparam int unsigned GRID_DIM = GRID_W * GRID_W;
  localparam int unsigned AW       = 4;
  localparam int unsigned MAX_TIME = 2;
  localparam int unsigned TW       = 1;
  localparam int unsigned MAX_OUT  = 4;
  localparam int unsigned PER_STEP = 3 * GRID_DIM + 4 * GRID_W - 4;
  localparam int unsigned RST_CELL = 37 % GRID_DIM;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          cell_ready = 1'b0;
  logic          cmpl = 1'b0;
  logic          busy, done, err, cell_valid, cell_last, buf_sel;
  logic [2:0]    phase;
  logic [AW-1:0] cell_addr;
  logic [TW-1:0] time_step;

  lbm_step_sequencer #(
    .GRID_W           (GRID_W),
    .GRID_DIM         (GRID_DIM),
    .ADDRESS_WIDTH    (AW),
    .MAX_TIME         (MAX_TIME),
    .TIME_COUNT_WIDTH (TW),
    .MAX_OUTSTANDING  (MAX_OUT)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst_n),
    .start      (start),
`ifdef LBM_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .busy       (busy),
    .done       (done),
    .err        (err),
    .phase      (phase),
    .cell_addr  (cell_addr),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_last  (cell_last),
    .cmpl       (cmpl),
    .time_step  (time_step),
    .buf_sel    (buf_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned ph;
    int unsigned addr;
    bit          last;
    int unsigned ts;
    bit          bs;
  } acc_t;

  acc_t        exp_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad = 0;
  int unsigned pend = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every accept of a whole run, in order: full grids for phases 1..3, then
  // the perimeter cells (row-major filter gives the required walk order).
  function automatic void build_expect();
    exp_q.delete();
    for (int t = 0; t < int'(MAX_TIME); t++) begin
      for (int ph = 1; ph <= 4; ph++) begin
        for (int a = 0; a < int'(GRID_DIM); a++) begin
          int r;
          int c;
          acc_t e;
          r = a / int'(GRID_W);
          c = a % int'(GRID_W);
          if (ph == 4 && !(r == 0 || r == int'(GRID_W) - 1 || c == 0 || c == int'(GRID_W) - 1))
            continue;
          e.ph = ph; e.addr = a; e.last = (a == int'(GRID_DIM) - 1); e.ts = t; e.bs = t[0];
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; cell_ready = 1'b0; cmpl = 1'b0; step = 1'b0;
    pend = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One cycle of a well-behaved datapath: retire one cell whenever one is pending.
  task automatic cycle_drive(input bit rdy);
    bit c;
    bit acc;
    c = (pend != 0);
    acc = cell_valid && rdy;
    cell_ready = rdy;
    cmpl = c;
    if (acc) pend++;
    if (c) pend--;
    @(negedge clk);
  endtask

  task automatic run_full(input bit rnd);
    int unsigned accepts = 0;
    int unsigned cyc = 0;
    int unsigned prev_phase = 1;
    bit          prev_wait = 1'b0;
    int unsigned prev_addr = 0;
    build_expect();
    pend = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_phase", phase, 1);
    check_eq("start_busy", busy, 1);
    check_eq("start_valid", cell_valid, 1);
    check_eq("start_addr", cell_addr, 0);
    check_eq("start_done", done, 0);
    check_eq("start_ts", time_step, 0);
    check_eq("start_bufsel", buf_sel, 0);
    while ((exp_q.size() != 0 || pend != 0) && cyc < 4000) begin
      bit c;
      bit acc;
      if (phase != prev_phase && phase >= 1 && phase <= 4) begin
        check_eq("entry_pend", pend, 0);
        check_eq("entry_valid", cell_valid, 1);
        if (exp_q.size() != 0) begin
          check_eq("entry_phase", phase, exp_q[0].ph);
          check_eq("entry_addr", cell_addr, exp_q[0].addr);
        end
      end
      if (pend >= MAX_OUT) check_eq("valid_at_max", cell_valid, 0);
      if (prev_wait) begin
        check_eq("hold_valid", cell_valid, 1);
        check_eq("hold_addr", cell_addr, prev_addr);
      end
      cell_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      c = (pend != 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      cmpl = c;
      step = (phase == 3'd6);
      acc = cell_valid && cell_ready;
      if (acc) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_accept", cell_addr, 32'hffff_ffff);
        end else begin
          acc_t e;
          e = exp_q.pop_front();
          check_eq("acc_phase", phase, e.ph);
          check_eq("acc_addr", cell_addr, e.addr);
          check_eq("acc_last", cell_last, e.last);
          check_eq("acc_ts", time_step, e.ts);
          check_eq("acc_bufsel", buf_sel, e.bs);
          check_eq("acc_err", err, 0);
        end
        accepts++;
      end
      if (acc) pend++;
      if (c) pend--;
      prev_phase = phase;
      prev_wait = cell_valid && !cell_ready;
      prev_addr = cell_addr;
      @(negedge clk);
      cyc++;
    end
    cmpl = 1'b0; cell_ready = 1'b0; step = 1'b0;
    check_eq("run_remaining", exp_q.size(), 0);
    check_eq("run_accepts", accepts, MAX_TIME * PER_STEP);
    // Dead cycle after the last retire, then DONE.
    check_eq("last_dead_phase", phase, 4);
    @(negedge clk);
    check_eq("done_flag", done, 1);
    check_eq("done_phase", phase, 5);
    check_eq("done_busy", busy, 0);
    check_eq("done_err", err, 0);
    check_eq("done_ts", time_step, MAX_TIME - 1);
    check_eq("done_bufsel", buf_sel, MAX_TIME % 2);
    check_eq("done_valid", cell_valid, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_acc;
    int unsigned a;
    bit          v;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_valid", cell_valid, 0);
    check_eq("rst_addr", cell_addr, 0);
    check_eq("rst_last", cell_last, 0);
    check_eq("rst_ts", time_step, 0);
    check_eq("rst_bufsel", buf_sel, 0);
    do_reset();

    run_full(1'b0);
    run_full(1'b1);

    // Outstanding limit, starting from DONE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("restart_done", done, 0);
    check_eq("restart_phase", phase, 1);
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cell_ready = 1'b1;
      cmpl = 1'b0;
      if (cell_valid) begin
        check_eq("lim_addr", cell_addr, n_acc);
        n_acc++;
      end
      @(negedge clk);
    end
    check_eq("lim_count", n_acc, MAX_OUT);
    check_eq("lim_valid", cell_valid, 0);
    cell_ready = 1'b0;
    cmpl = 1'b1;
    @(negedge clk);
    cmpl = 1'b0;
    check_eq("lim_resume_valid", cell_valid, 1);
    check_eq("lim_resume_addr", cell_addr, MAX_OUT);
    do_reset();

    // cell_ready held low at address 9
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !(cell_valid && cell_addr == 9); k++) cycle_drive(1'b1);
    check_eq("reach_addr9", cell_addr, 9);
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b0);
      check_eq("stall_valid", cell_valid, 1);
      check_eq("stall_addr", cell_addr, 9);
    end
    cycle_drive(1'b1);
    check_eq("stall_release_addr", cell_addr, 10);
    do_reset();

    // Reset mid-STREAM, then a stray completion
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && !(phase == 3 && cell_addr == RST_CELL); k++) cycle_drive(1'b1);
    check_eq("reach_stream_cell", cell_addr, RST_CELL);
    rst_n = 1'b0;
    cmpl = 1'b0;
    cell_ready = 1'b0;
    pend = 0;
    #1;
    check_eq("abort_phase", phase, 0);
    check_eq("abort_valid", cell_valid, 0);
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ts", time_step, 0);
    check_eq("abort_phase2", phase, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cmpl = 1'b1;
    @(negedge clk);
    cmpl = 1'b0;
    check_eq("stray_cmpl_err", err, 1);
    check_eq("stray_cmpl_phase", phase, 0);

    // start clears err; start while busy is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("clr_err", err, 0);
    check_eq("clr_phase", phase, 1);
    for (int k = 0; k < 300 && !(phase == 2 && cell_addr == 3); k++) cycle_drive(1'b1);
    check_eq("reach_collide", phase, 2);
    a = cell_addr;
    v = cell_valid;
    start = 1'b1;
    cycle_drive(1'b1);
    start = 1'b0;
    check_eq("busy_start_phase", phase, 2);
    check_eq("busy_start_addr", cell_addr, a + v);
    check_eq("busy_start_err", err, 0);
    do_reset();

`ifdef LBM_SEQ_SINGLE_STEP_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 500 && phase != 6; k++) cycle_drive(1'b1);
    cmpl = 1'b0;
    check_eq("hold_phase", phase, 6);
    check_eq("hold_ts", time_step, 1);
    check_eq("hold_bufsel", buf_sel, 1);
    check_eq("hold_busy", busy, 1);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      cell_ready = 1'b1;
      if (cell_valid) n_acc++;
      @(negedge clk);
    end
    check_eq("hold_no_accept", n_acc, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_eq("step_phase", phase, 1);
    check_eq("step_addr", cell_addr, 0);
    check_eq("step_valid", cell_valid, 1);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
